// File: rtl/ds_temp_to_bcd_if.sv
// Bundle of the converter's F1M strobe, request/snapshot inputs and result outputs.
// The master side drives requests; the converter itself attaches as slave.
interface ds_temp_to_bcd_if #(
    parameter int CHANNELS    = 4,
    parameter int FRAC_DIGITS = 1
);
    localparam int W = 12 + 4 * FRAC_DIGITS;

    logic                    F1M;
    logic                    convert_en;
    logic [16*CHANNELS-1:0]  bin_temperature;
    logic                    busy;
    logic                    done;
    logic [W*CHANNELS-1:0]   dec_temperature;
    logic [CHANNELS-1:0]     sign;
    logic [CHANNELS-1:0]     range_err;

    modport master (
        output F1M, convert_en, bin_temperature,
        input  busy, done, dec_temperature, sign, range_err
    );

    modport slave (
        input  F1M, convert_en, bin_temperature,
        output busy, done, dec_temperature, sign, range_err
    );
endinterface

// File: rtl/ds_temp_to_bcd.sv
// Time-multiplexed DS18B20 word to signed BCD converter: per channel one LOAD,
// seven double-dabble SHIFTs and one STORE, then all channels publish at once.
module ds_temp_to_bcd #(
    parameter int CHANNELS    = 4,
    parameter int RES_BITS    = 12,
    parameter int FRAC_DIGITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    ds_temp_to_bcd_if.slave   bus
);
    localparam int W     = 12 + 4 * FRAC_DIGITS;
    localparam int FW    = 4 * FRAC_DIGITS;
    localparam int NW    = 16 * CHANNELS;
    localparam int DW    = W * CHANNELS;
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SCALE = (FRAC_DIGITS == 1) ? 10 : 100;
    localparam logic [15:0] RES_MASK = 16'hFFFF << (12 - RES_BITS);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, PUBLISH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [NW-1:0]         snap_q, snap_d;
    logic [18:0]           dd_q, dd_d;
    logic [FW-1:0]         frac_q, frac_d;
    logic                  neg_q, neg_d;
    logic                  err_q, err_d;
    logic [DW-1:0]         sh_dec_q, sh_dec_d;
    logic [CHANNELS-1:0]   sh_sign_q, sh_sign_d;
    logic [CHANNELS-1:0]   sh_err_q, sh_err_d;
    logic [DW-1:0]         dec_q, dec_d;
    logic [CHANNELS-1:0]   sign_q, sign_d;
    logic [CHANNELS-1:0]   rerr_q, rerr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [15:0]           word;
    logic [11:0]           mag;
    logic [10:0]           fprod;
    logic [6:0]            fround;
    logic [3:0]            ftens, fones;
    logic [18:0]           dd_adj;

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        dd_d      = dd_q;
        frac_d    = frac_q;
        neg_d     = neg_q;
        err_d     = err_q;
        sh_dec_d  = sh_dec_q;
        sh_sign_d = sh_sign_q;
        sh_err_d  = sh_err_q;
        dec_d     = dec_q;
        sign_d    = sign_q;
        rerr_d    = rerr_q;
        busy_d    = busy_q;
        done_d    = bus.F1M && (state_q == PUBLISH);

        word   = snap_q[16*int'(ch_q) +: 16] & RES_MASK;
        mag    = {1'b0, word[10:0] ^ {11{word[11]}}} + {11'b0, word[11]};
        fprod  = 11'(mag[3:0]) * 11'(SCALE) + 11'd8;
        fround = 7'(fprod >> 4);
        ftens  = 4'(fround / 7'd10);
        fones  = 4'(fround % 7'd10);

        // BCD digits sit above the binary remainder in one register so the
        // adjusted value shifts as a single word.
        dd_adj = dd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (dd_adj[7+4*i +: 4] >= 4'd5) begin
                dd_adj[7+4*i +: 4] = dd_adj[7+4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.convert_en) begin
                    snap_d  = bus.bin_temperature;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                err_d   = !((word[15:11] == '0) || (word[15:11] == '1)) || mag[11];
                neg_d   = word[11];
                dd_d    = {12'b0, mag[10:4]};
                frac_d  = FW'({ftens, fones});
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                dd_d  = dd_adj << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                sh_dec_d[W*int'(ch_q) +: W] = err_q ? '0 : {dd_q[18:7], frac_q};
                sh_sign_d[ch_q] = !err_q && neg_q && ({dd_q[18:7], frac_q} != '0);
                sh_err_d[ch_q]  = err_q;
                if (ch_q == CW'(CHANNELS - 1)) begin
                    state_d = PUBLISH;
                end else begin
                    ch_d    = ch_q + CW'(1);
                    state_d = LOAD;
                end
            end
            PUBLISH: begin
                dec_d   = sh_dec_q;
                sign_d  = sh_sign_q;
                rerr_d  = sh_err_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            snap_q    <= '0;
            dd_q      <= '0;
            frac_q    <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            sh_dec_q  <= '0;
            sh_sign_q <= '0;
            sh_err_q  <= '0;
            dec_q     <= '0;
            sign_q    <= '0;
            rerr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // done is a plain clk pulse so it lasts one cycle however sparse F1M is
            done_q <= done_d;
            if (bus.F1M) begin
                state_q   <= state_d;
                ch_q      <= ch_d;
                cnt_q     <= cnt_d;
                snap_q    <= snap_d;
                dd_q      <= dd_d;
                frac_q    <= frac_d;
                neg_q     <= neg_d;
                err_q     <= err_d;
                sh_dec_q  <= sh_dec_d;
                sh_sign_q <= sh_sign_d;
                sh_err_q  <= sh_err_d;
                dec_q     <= dec_d;
                sign_q    <= sign_d;
                rerr_q    <= rerr_d;
                busy_q    <= busy_d;
            end
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.dec_temperature = dec_q;
    assign bus.sign            = sign_q;
    assign bus.range_err       = rerr_q;
endmodule

// File: tb/tb_ds_temp_to_bcd.sv
// Scoreboard bench for three converter configurations (defaults, 9-bit/1-channel,
// 2-fraction-digit/2-channel) against an arithmetic reference of the temperature rules.
module tb_ds_temp_to_bcd;
    logic clk;
    logic rst;
    logic f1m;
    bit   f1m_on;
    bit   gaps;
    int unsigned edge_no;
    int unsigned busy_until [3];
    int unsigned done_cnt [3];
    bit          prev_done [3];
    int unsigned n_vec;
    int unsigned n_bad;

    typedef struct {
        int          d;
        logic [79:0] dec;
        logic [3:0]  sg;
        logic [3:0]  er;
        int unsigned pub;
    } exp_t;

    typedef struct {
        logic [79:0] dec;
        logic [3:0]  sg;
        logic [3:0]  er;
        logic        busy;
        logic        done;
    } out_t;

    exp_t sb [$];

    ds_temp_to_bcd_if #(.CHANNELS(4), .FRAC_DIGITS(1)) if0 ();
    ds_temp_to_bcd_if #(.CHANNELS(1), .FRAC_DIGITS(1)) if1 ();
    ds_temp_to_bcd_if #(.CHANNELS(2), .FRAC_DIGITS(2)) if2 ();

    ds_temp_to_bcd #(.CHANNELS(4), .RES_BITS(12), .FRAC_DIGITS(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    ds_temp_to_bcd #(.CHANNELS(1), .RES_BITS(9),  .FRAC_DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    ds_temp_to_bcd #(.CHANNELS(2), .RES_BITS(12), .FRAC_DIGITS(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int chn(int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 2;
    endfunction

    task automatic chk(string nm, int d, logic [79:0] act, logic [79:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, req, $time);
        end
    endtask

    // Reference: {range_err, sign, digits right-aligned}
    function automatic logic [21:0] ref_ch(logic [15:0] word, int res, int fd);
        logic [15:0] m;
        logic [19:0] dg;
        int v, a, ip, fr, scale;
        bit neg;
        m     = word & (16'hFFFF << (12 - res));
        v     = int'($signed(m));
        neg   = (v < 0);
        a     = neg ? -v : v;
        if (a >= 2048) return {1'b1, 1'b0, 20'd0};
        ip    = a / 16;
        scale = (fd == 1) ? 10 : 100;
        fr    = ((a % 16) * scale * 2 + 16) / 32;
        if (fd == 1)
            dg = 20'((ip / 100) * 4096 + ((ip / 10) % 10) * 256 + (ip % 10) * 16 + fr);
        else
            dg = 20'((ip / 100) * 65536 + ((ip / 10) % 10) * 4096 + (ip % 10) * 256
                     + (fr / 10) * 16 + (fr % 10));
        return {1'b0, neg && (ip != 0 || fr != 0), dg};
    endfunction

    function automatic exp_t expect_for(int d, logic [63:0] bin);
        exp_t e;
        logic [21:0] r;
        int fd, res, w;
        fd    = (d == 2) ? 2 : 1;
        res   = (d == 1) ? 9 : 12;
        w     = 12 + 4 * fd;
        e.d   = d;
        e.dec = '0;
        e.sg  = '0;
        e.er  = '0;
        e.pub = 0;
        for (int n = 0; n < chn(d); n++) begin
            r = ref_ch(bin[16*n +: 16], res, fd);
            e.dec = e.dec | (80'(r[19:0]) << (n * w));
            e.sg[n] = r[20];
            e.er[n] = r[21];
        end
        return e;
    endfunction

    function automatic out_t get_out(int d);
        out_t o;
        case (d)
            0: begin
                o.dec = 80'(if0.dec_temperature); o.sg = 4'(if0.sign); o.er = 4'(if0.range_err);
                o.busy = if0.busy; o.done = if0.done;
            end
            1: begin
                o.dec = 80'(if1.dec_temperature); o.sg = 4'(if1.sign); o.er = 4'(if1.range_err);
                o.busy = if1.busy; o.done = if1.done;
            end
            default: begin
                o.dec = 80'(if2.dec_temperature); o.sg = 4'(if2.sign); o.er = 4'(if2.range_err);
                o.busy = if2.busy; o.done = if2.done;
            end
        endcase
        return o;
    endfunction

    task automatic drive(int d, logic en, logic [63:0] bin);
        case (d)
            0: begin if0.convert_en = en; if0.bin_temperature = bin; end
            1: begin if1.convert_en = en; if1.bin_temperature = bin[15:0]; end
            default: begin if2.convert_en = en; if2.bin_temperature = bin[31:0]; end
        endcase
    endtask

    function automatic logic [15:0] rnd_word();
        logic [11:0] t;
        case ($urandom_range(0, 4))
            0: return 16'($urandom);
            1: begin
                case ($urandom_range(0, 5))
                    0: return 16'h07FF;
                    1: return 16'hF801;
                    2: return 16'hF800;
                    3: return 16'h0800;
                    4: return 16'hFFFF;
                    default: return 16'h0000;
                endcase
            end
            default: begin
                t = 12'($urandom);
                return {{4{t[11]}}, t};
            end
        endcase
    endfunction

    function automatic logic [63:0] rnd_bin();
        return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    endfunction

    // Raise convert_en, wait for the first F1M edge at which the model says the
    // converter is idle, and queue the expected publication for that request.
    task automatic request(int d, logic [63:0] bin, bit hold);
        exp_t e;
        bit acc;
        @(negedge clk);
        drive(d, 1'b1, bin);
        acc = 1'b0;
        for (int n = 0; n < 3000 && !acc; n++) begin
            @(posedge clk);
            if (f1m && edge_no > busy_until[d]) acc = 1'b1;
        end
        chk("accept", d, 80'(acc), 80'(1));
        if (acc) begin
            e = expect_for(d, bin);
            e.pub = edge_no + 9 * chn(d) + 1;
            sb.push_back(e);
            busy_until[d] = e.pub;
        end
        @(negedge clk);
        drive(d, hold, rnd_bin());
    endtask

    // F1M strobe, optionally with random gaps; edge_no numbers the F1M edges.
    initial begin
        f1m = 1'b0;
        edge_no = 0;
        if0.F1M = 1'b0; if1.F1M = 1'b0; if2.F1M = 1'b0;
        forever begin
            @(negedge clk);
            if (!f1m_on)   f1m = 1'b0;
            else if (gaps) f1m = ($urandom_range(0, 2) != 0);
            else           f1m = 1'b1;
            if0.F1M = f1m; if1.F1M = f1m; if2.F1M = f1m;
            if (f1m) edge_no++;
        end
    end

    // Monitor: every done pulse is matched to the oldest pending request of that DUT.
    initial begin
        out_t o;
        int idx;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                o = get_out(d);
                if (o.done === 1'b1) begin
                    done_cnt[d]++;
                    chk("done_width", d, 80'(prev_done[d]), 80'(0));
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].d == d) begin idx = i; break; end
                    end
                    chk("done_expected", d, 80'(idx >= 0), 80'(1));
                    if (idx >= 0) begin
                        chk("dec", d, o.dec, sb[idx].dec);
                        chk("sign", d, 80'(o.sg), 80'(sb[idx].sg));
                        chk("range_err", d, 80'(o.er), 80'(sb[idx].er));
                        chk("latency_f1m", d, 80'(edge_no), 80'(sb[idx].pub));
                        chk("busy_at_done", d, 80'(o.busy), 80'(0));
                        sb.delete(idx);
                    end
                end
                prev_done[d] = (o.done === 1'b1);
            end
        end
    end

    initial begin
        out_t o;
        int unsigned base;
        int unsigned k;
        int dsel;
        n_vec = 0; n_bad = 0;
        busy_until = '{0, 0, 0};
        done_cnt   = '{0, 0, 0};
        prev_done  = '{0, 0, 0};
        f1m_on = 1'b0; gaps = 1'b0;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, '0);

        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            o = get_out(d);
            chk("reset_dec", d, o.dec, '0);
            chk("reset_sign", d, 80'(o.sg), '0);
            chk("reset_rerr", d, 80'(o.er), '0);
            chk("reset_busy", d, 80'(o.busy), '0);
            chk("reset_done", d, 80'(o.done), '0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        f1m_on = 1'b1;

        // Abort mid-conversion
        request(0, 64'hFC90_07D0_FF5E_0191, 1'b0);
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        o = get_out(0);
        chk("abort_busy", 0, 80'(o.busy), '0);
        chk("abort_dec", 0, o.dec, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == 0) sb.delete(i);
        busy_until[0] = edge_no;
        base = done_cnt[0];
        repeat (120) @(negedge clk);
        chk("abort_no_done", 0, 80'(done_cnt[0]), 80'(base));
        o = get_out(0);
        chk("abort_outputs", 0, {o.dec[71:0], o.sg, o.er}, '0);

        // Directed vectors
        request(0, 64'hFC90_07D0_FF5E_0191, 1'b0);
        request(1, 64'h0191, 1'b0);
        request(1, 64'h019F, 1'b0);
        request(2, {32'h0, 16'h0008, 16'hFFFF}, 1'b0);
        request(0, {16'h07D0, 16'hFC90, 16'hF800, 16'h0800}, 1'b0);

        // convert_en pulsed while busy must be ignored
        request(0, rnd_bin(), 1'b0);
        drive(0, 1'b1, rnd_bin());
        repeat (4) @(negedge clk);
        o = get_out(0);
        chk("busy_during", 0, 80'(o.busy), 80'(1));
        drive(0, 1'b0, rnd_bin());

        // Back-to-back with convert_en held high
        request(1, rnd_bin(), 1'b1);
        request(1, rnd_bin(), 1'b1);
        request(1, rnd_bin(), 1'b0);
        request(0, rnd_bin(), 1'b1);
        request(0, rnd_bin(), 1'b0);

        // Random traffic with gapped F1M
        gaps = 1'b1;
        for (int r = 0; r < 25; r++) begin
            dsel = $urandom_range(0, 2);
            k = $urandom_range(1, 3);
            for (int j = 0; j < int'(k); j++) request(dsel, rnd_bin(), j != int'(k) - 1);
        end

        for (int n = 0; n < 20000 && sb.size() != 0; n++) @(posedge clk);
        chk("drain", 0, 80'(sb.size()), '0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
